datapath_unit: RTL and testbench
================================

// Module: datapath_unit
// PURPOSE
//  Execution datapath driven by the processor control FSM's control word each cycle.
//  Holds the 16x16 register file, 256x16 data RAM with synchronous read, ALU and write-back mux.
//  Executes LOAD (two-cycle), STORE, ADD, SUB and NOOP control words; sits between the control FSM and data memory.
// PARAMETERS
//  DATA_W        16   datapath word width
//  RF_AW         4    register file address width (2**RF_AW entries)
//  DM_AW         8    data RAM address width (2**DM_AW words)
//  DM_INIT_FILE  ""   hex file loaded into data RAM via $readmemh at elaboration; "" = no preload
// PORTS
//  clk         in   1       clock, all state on rising edge
//  Reset       in   1       synchronous, active-low reset
//  D_addr      in   DM_AW   data RAM address
//  D_wr        in   1       data RAM write enable (write data = Ra_data)
//  RF_s        in   1       write-back select: 1 = D_rdata, 0 = ALU_Q
//  RF_W_addr   in   RF_AW   register file write address
//  RF_W_en     in   1       register file write enable
//  RF_Ra_addr  in   RF_AW   read port A address
//  RF_Rb_addr  in   RF_AW   read port B address
//  ALU_s0      in   3       ALU operation select
//  Ra_data     out  DATA_W  register file port A read data (combinational)
//  Rb_data     out  DATA_W  register file port B read data (combinational)
//  ALU_Q       out  DATA_W  ALU result (combinational)
//  D_rdata     out  DATA_W  registered data RAM read data
//  W_data      out  DATA_W  write-back mux output
//  flags       out  4       {Z,N,C,V} status register (see CONFIGURATION)
// BEHAVIOUR
//  Reset (Reset==0 at posedge): all 16 registers <= 0; D_rdata <= 0; flags <= 0; RAM contents retained.
//  RAM writes are suppressed during reset. RF writes are suppressed during reset. Reset wins over any simultaneous write.
//  RF: combinational read. Write at posedge when RF_W_en: RF[RF_W_addr] <= W_data.
//  Read of the address being written returns the old value until the edge (no bypass).
//  RAM: every posedge D_rdata <= mem[D_addr] (1-cycle latency, read-first).
//  When D_wr: mem[D_addr] <= Ra_data. Same-edge read of that address returns the old contents.
//  LOAD timing: cycle 1 presents D_addr (RF_W_en=0). Cycle 2 holds D_addr with RF_s=1 and RF_W_en=1, and writes D_rdata.
//  STORE: one cycle, D_wr=1, data from RF_Ra_addr.
//  W_data = RF_s ? D_rdata : ALU_Q.
//  ALU (A=Ra_data, B=Rb_data, modulo 2**DATA_W, wrap silently):
//   000 Q=A; 001 Q=A+B; 010 Q=A-B; 011 Q=A&B; 100 Q=A|B; 101..111 Q=0.
//  Simultaneous D_wr and RF_W_en are both performed; neither blocks the other.
//  Address inputs are used at full width; there is no out-of-range case.
// CONFIGURATION
//  Macro DATAPATH_ALU_FLAGS_EN defined: flags register updates at posedge when RF_W_en && !RF_s && Reset.
//   Z = (ALU_Q==0); N = ALU_Q[DATA_W-1].
//   C = carry-out of ADD, or borrow (A<B unsigned) of SUB; 0 for other ops.
//   V = signed overflow of ADD/SUB; 0 for other ops.
//   Flags hold otherwise.
//  Macro undefined: flags port present, tied to 4'b0000; no flag logic.
// STRUCTURE
//  Shared package datapath_pkg: ALU select localparams ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR; typedef word_t (logic [DATA_W-1:0]).
//  One sub-module: register_file (2 async read ports, 1 sync write port, sync clear).
//  ALU, RAM and write-back mux stay inline.
// TESTING
//  1 Reset=0 for 2 cycles, then release -> Ra_data==0 for all addresses 0..15; D_rdata==0.
//  2 Preload RAM[0x6A]=16'h1234. Cycle 1: D_addr=6A, RF_s=1, RF_W_en=0. Cycle 2: same with RF_W_en=1, RF_W_addr=A -> RF[A]==16'h1234, RF[A] unchanged after cycle 1.
//  3 RF[5]=16'h7FFF, RF[3]=1; ALU_s0=001, W_addr=6, W_en=1 -> RF[6]==16'h8000 (wrap); with flag macro, flags=={0,1,0,1}.
//  4 RF[1]=2, RF[2]=3; ALU_s0=010, W_addr=5 -> RF[5]==16'hFFFF; with flag macro, flags C==1.
//  5 RF[A]=16'hBEEF; D_wr=1, D_addr=6A, RF_Ra_addr=A -> D_rdata shows old value that edge; re-read next cycle gives 16'hBEEF.
//  6 Reset=0 in the same cycle as D_wr=1 and RF_W_en=1 -> RAM word unchanged, all RF entries==0.
//  7 ALU_s0=111 with W_en=1 -> target register written 0. ALU_s0=000 -> ALU_Q==Ra_data.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared definitions for the execution datapath: ALU operation encodings and the
// native word type.
package datapath_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;

endpackage

// File: rtl/datapath_unit_register_file.sv
// Register file for the datapath.
// It has two combinational read ports and one synchronous write port.
// An active-low synchronous clear wins over a write on the same edge.
// Reads of the entry being written return the old value until the edge; there is
// no bypass.
module register_file
    import datapath_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              w_en,
    input  logic [AW-1:0]     w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    localparam int DEPTH = 2 ** AW;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Next register contents: clear everything in reset, otherwise apply the write.
    always_comb begin
        regs_d = regs_q;
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_d[i] = '0;
            end
        end else if (w_en) begin
            regs_d[w_addr] = w_data;
        end
    end

    // Register storage update.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, synchronous-read data RAM, ALU and write-back mux.
// The control FSM drives the control inputs each cycle.
// Optional feature macro: DATAPATH_ALU_FLAGS_EN enables the {Z,N,C,V} status
// register. Without it, flags is tied to zero.
module datapath_unit
    import datapath_pkg::*;
#(
    parameter int    DATA_W       = WORD_W,
    parameter int    RF_AW        = 4,
    parameter int    DM_AW        = 8,
    parameter string DM_INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [DM_AW-1:0]  D_addr,
    input  logic              D_wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_Ra_addr,
    input  logic [RF_AW-1:0]  RF_Rb_addr,
    input  logic [2:0]        ALU_s0,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic [DATA_W-1:0] ALU_Q,
    output logic [DATA_W-1:0] D_rdata,
    output logic [DATA_W-1:0] W_data,
    output logic [3:0]        flags
);

    localparam int DM_DEPTH = 2 ** DM_AW;

    logic [DATA_W-1:0] mem_q [DM_DEPTH];
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] d_rdata_d;
    logic              mem_we_d;

    register_file #(
        .DATA_W (DATA_W),
        .AW     (RF_AW)
    ) u_rf (
        .clk     (clk),
        .Reset   (Reset),
        .w_en    (RF_W_en),
        .w_addr  (RF_W_addr),
        .w_data  (W_data),
        .ra_addr (RF_Ra_addr),
        .rb_addr (RF_Rb_addr),
        .ra_data (Ra_data),
        .rb_data (Rb_data)
    );

    // ALU: wraps modulo 2**DATA_W; unused encodings produce zero.
    always_comb begin
        ALU_Q = '0;
        case (ALU_s0)
            ALU_PASS: ALU_Q = Ra_data;
            ALU_ADD:  ALU_Q = Ra_data + Rb_data;
            ALU_SUB:  ALU_Q = Ra_data - Rb_data;
            ALU_AND:  ALU_Q = Ra_data & Rb_data;
            ALU_OR:   ALU_Q = Ra_data | Rb_data;
            default:  ALU_Q = '0;
        endcase
    end

    assign W_data = RF_s ? D_rdata : ALU_Q;

    // RAM read is read-first, and reset forces the read register to zero and blocks writes.
    always_comb begin
        mem_we_d  = D_wr && Reset;
        d_rdata_d = Reset ? mem_q[D_addr] : '0;
    end

    // RAM array write and registered read data.
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[D_addr] <= Ra_data;
        end
        d_rdata_q <= d_rdata_d;
    end

    assign D_rdata = d_rdata_q;

`ifdef DATAPATH_ALU_FLAGS_EN
    logic [3:0]      flags_q;
    logic [3:0]      flags_d;
    logic [DATA_W:0] add_wide;
    logic            sign_a;
    logic            sign_b;
    logic            sign_q;

    // Status flags track ALU results that are written back to the register file.
    always_comb begin
        flags_d  = flags_q;
        add_wide = {1'b0, Ra_data} + {1'b0, Rb_data};
        sign_a   = Ra_data[DATA_W-1];
        sign_b   = Rb_data[DATA_W-1];
        sign_q   = ALU_Q[DATA_W-1];
        if (RF_W_en && !RF_s) begin
            flags_d[3] = (ALU_Q == '0);
            flags_d[2] = sign_q;
            flags_d[1] = 1'b0;
            flags_d[0] = 1'b0;
            if (ALU_s0 == ALU_ADD) begin
                flags_d[1] = add_wide[DATA_W];
                flags_d[0] = (sign_a == sign_b) && (sign_q != sign_a);
            end else if (ALU_s0 == ALU_SUB) begin
                flags_d[1] = (Ra_data < Rb_data);
                flags_d[0] = (sign_a != sign_b) && (sign_q != sign_a);
            end
        end
    end

    // Status register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Testbench for datapath_unit.
// It runs directed LOAD/STORE/ALU sequences and then randomized control words.
// A behavioural model inside the bench predicts the outputs.
// The expected values go through a queue to a separate monitor.
// Build with DATAPATH_ALU_FLAGS_EN defined to also check the status flags.
module tb_datapath_unit;

    logic        clk;
    logic        Reset;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [15:0] Ra_data;
    logic [15:0] Rb_data;
    logic [15:0] ALU_Q;
    logic [15:0] D_rdata;
    logic [15:0] W_data;
    logic [3:0]  flags;

    typedef struct {
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] q;
        logic [15:0] w;
        logic [15:0] rd;
        logic [3:0]  fl;
    } exp_t;

    exp_t exp_q[$];

    logic [15:0] m_rf  [16];
    logic [15:0] m_mem [256];
    logic [15:0] m_rdata;
    logic [3:0]  m_flags;

    int vectors;
    int miscompares;
    bit stim_done;

    datapath_unit dut (
        .clk        (clk),
        .Reset      (Reset),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .Ra_data    (Ra_data),
        .Rb_data    (Rb_data),
        .ALU_Q      (ALU_Q),
        .D_rdata    (D_rdata),
        .W_data     (W_data),
        .flags      (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one control word (one clock cycle) and optionally queue what the model predicts.
    // The model state then advances to what the coming edge should produce.
    task automatic apply_stimulus(input logic rst_n, input logic [7:0] addr, input logic wr,
                                  input logic rf_s, input logic [3:0] wa, input logic wen,
                                  input logic [3:0] ra, input logic [3:0] rb,
                                  input logic [2:0] op, input bit check);
        exp_t e;
        int a, b, sa, sb, res;
        bit c, v;
        @(posedge clk);
        #1;
        Reset = rst_n; D_addr = addr; D_wr = wr; RF_s = rf_s; RF_W_addr = wa;
        RF_W_en = wen; RF_Ra_addr = ra; RF_Rb_addr = rb; ALU_s0 = op;
        a  = int'(m_rf[ra]);
        b  = int'(m_rf[rb]);
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        c  = 1'b0;
        v  = 1'b0;
        case (op)
            3'd0: res = a;
            3'd1: begin res = a + b; c = (res > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            3'd2: begin res = a - b; c = (a < b);       v = (sa - sb > 32767) || (sa - sb < -32768); end
            3'd3: res = a & b;
            3'd4: res = a | b;
            default: res = 0;
        endcase
        e.ra = m_rf[ra];
        e.rb = m_rf[rb];
        e.q  = 16'(res);
        e.w  = rf_s ? m_rdata : e.q;
        e.rd = m_rdata;
        e.fl = m_flags;
        if (check) exp_q.push_back(e);
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
            m_rdata = 16'h0000;
            m_flags = 4'h0;
        end else begin
            m_rdata = m_mem[addr];
            if (wr) m_mem[addr] = e.ra;
`ifdef DATAPATH_ALU_FLAGS_EN
            if (wen && !rf_s) m_flags = {(e.q == 16'h0000), e.q[15], c, v};
`endif
            if (wen) m_rf[wa] = e.w;
        end
    endtask

    // Two-cycle LOAD of RAM word addr into register rd; rd is also read on port A.
    task automatic load_reg(input logic [3:0] rd, input logic [7:0] addr);
        apply_stimulus(1'b1, addr, 1'b0, 1'b1, rd, 1'b0, rd, 4'd0, 3'd0, 1'b1);
        apply_stimulus(1'b1, addr, 1'b0, 1'b1, rd, 1'b1, rd, 4'd0, 3'd0, 1'b1);
    endtask

    // Idle cycle that just reads two registers.
    task automatic read_regs(input logic [3:0] ra, input logic [3:0] rb);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, ra, rb, 3'd0, 1'b1);
    endtask

    task automatic check_field(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s vector %0d: got %h expected %h", name, vectors, act, exp);
        end
    endtask

    // Compare every observable output against one queued expectation.
    task automatic check_output(input exp_t e);
        vectors++;
        check_field("Ra_data", Ra_data, e.ra);
        check_field("Rb_data", Rb_data, e.rb);
        check_field("ALU_Q",   ALU_Q,   e.q);
        check_field("W_data",  W_data,  e.w);
        check_field("D_rdata", D_rdata, e.rd);
        check_field("flags",   {12'h000, flags}, {12'h000, e.fl});
    endtask

    // Monitor: samples between active edges and consumes queued expectations.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) check_output(exp_q.pop_front());
        end
    end

    // Stimulus: backdoor RAM preload, directed scenarios, then random control words.
    initial begin
        stim_done = 1'b0;
        vectors = 0;
        miscompares = 0;
        Reset = 1'b0; D_addr = '0; D_wr = 1'b0; RF_s = 1'b0; RF_W_addr = '0;
        RF_W_en = 1'b0; RF_Ra_addr = '0; RF_Rb_addr = '0; ALU_s0 = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'($urandom);
        m_mem[8'h6A] = 16'h1234;
        m_mem[8'h10] = 16'h7FFF;
        m_mem[8'h11] = 16'h0001;
        m_mem[8'h12] = 16'h0002;
        m_mem[8'h13] = 16'h0003;
        m_mem[8'h14] = 16'hBEEF;
        m_mem[8'h15] = 16'h5A5A;
        for (int i = 0; i < 256; i++) dut.mem_q[i] = m_mem[i];

        // Reset held low for two cycles; outputs are unknown until the first edge.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
        for (int i = 0; i < 16; i++) read_regs(4'(i), 4'(15 - i));

        // LOAD of the 0x6A word into register 10.
        load_reg(4'hA, 8'h6A);
        read_regs(4'hA, 4'h0);

        // Wrapping add 0x7FFF + 1 into register 6.
        load_reg(4'd5, 8'h10);
        load_reg(4'd3, 8'h11);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0, 4'd6, 1'b1, 4'd5, 4'd3, 3'd1, 1'b1);
        read_regs(4'd6, 4'd5);

        // Borrowing subtract 2 - 3 into register 5.
        load_reg(4'd1, 8'h12);
        load_reg(4'd2, 8'h13);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0, 4'd5, 1'b1, 4'd1, 4'd2, 3'd2, 1'b1);
        read_regs(4'd5, 4'd1);

        // STORE with a read of the same address on the same edge, then a re-read.
        load_reg(4'hA, 8'h14);
        apply_stimulus(1'b1, 8'h6A, 1'b1, 1'b0, 4'd0, 1'b0, 4'hA, 4'd0, 3'd0, 1'b1);
        apply_stimulus(1'b1, 8'h6A, 1'b0, 1'b0, 4'd0, 1'b0, 4'hA, 4'd0, 3'd0, 1'b1);
        apply_stimulus(1'b1, 8'h6A, 1'b0, 1'b0, 4'd0, 1'b0, 4'hA, 4'd0, 3'd0, 1'b1);

        // Reset takes priority over a simultaneous RAM write and RF write.
        load_reg(4'd7, 8'h15);
        apply_stimulus(1'b0, 8'h6A, 1'b1, 1'b0, 4'd7, 1'b1, 4'd7, 4'd0, 3'd0, 1'b1);
        apply_stimulus(1'b1, 8'h6A, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'hA, 3'd0, 1'b1);
        apply_stimulus(1'b1, 8'h6A, 1'b0, 1'b0, 4'd0, 1'b0, 4'd7, 4'hA, 3'd0, 1'b1);

        // Unused ALU encoding writes zero, and PASS reproduces port A.
        load_reg(4'd9, 8'h14);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0, 4'd9, 1'b1, 4'd9, 4'd9, 3'd7, 1'b1);
        load_reg(4'd4, 8'h15);
        apply_stimulus(1'b1, 8'h00, 1'b0, 1'b0, 4'd8, 1'b1, 4'd4, 4'd9, 3'd0, 1'b1);
        read_regs(4'd9, 4'd8);

        // Randomized control words; reset is asserted occasionally.
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(($urandom_range(0, 49) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
                           1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                           3'($urandom_range(0, 7)), 1'b1);
        end

        stim_done = 1'b1;
    end

    // Wait for the monitor to drain the queue within a bounded time, then report.
    initial begin
        wait (stim_done);
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
